// File: rtl/register_file_pkg.sv
// Shared definitions for the register file: default geometry, named register
// indices used by benches and neighbouring blocks, and the read-source enum.
package register_file_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 32;
   localparam int unsigned DEFAULT_ADDR_WIDTH = 5;

   // Named architectural registers
   localparam int unsigned REG_ZERO = 0;
   localparam int unsigned REG_T0   = 8;
   localparam int unsigned REG_SP   = 29;
   localparam int unsigned REG_RA   = 31;

   // Where a read port takes its value from in a given cycle
   typedef enum logic [1:0] {
      READ_STORED = 2'd0,
      READ_BYPASS = 2'd1,
      READ_ZERO   = 2'd2
   } readSource_e;

endpackage

// File: rtl/register_read_port.sv
// One combinational read port: applies the reset force-to-zero, the
// hard-wired zero register and the optional write-to-read bypass on top of
// the value fetched from the storage array.
module register_read_port
   import register_file_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter bit          BYPASS     = 1'b1
) (
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] readReg_i,
   input  logic [DATA_WIDTH-1:0] storedData_i,
   input  logic                  writeEn_i,
   input  logic [ADDR_WIDTH-1:0] writeReg_i,
   input  logic [DATA_WIDTH-1:0] writeData_i,
   output logic [DATA_WIDTH-1:0] readData_o
);

   readSource_e readSource;
   logic        indexIsZero;
   logic        bypassHit;

   // Decide which source feeds the port; reset and register 0 outrank bypass
   always_comb begin
      indexIsZero = (readReg_i == '0);
      bypassHit   = BYPASS && writeEn_i && (writeReg_i != '0) && (writeReg_i == readReg_i);
      readSource  = READ_STORED;
      if (rst_i || indexIsZero) begin
         readSource = READ_ZERO;
      end else if (bypassHit) begin
         readSource = READ_BYPASS;
      end
   end

   // Steer the selected source onto the output
   always_comb begin
      readData_o = storedData_i;
      case (readSource)
         READ_ZERO:   readData_o = '0;
         READ_BYPASS: readData_o = writeData_i;
         default:     readData_o = storedData_i;
      endcase
   end

endmodule

// File: rtl/register_file.sv
// Architectural register file: 2**ADDR_WIDTH entries, two combinational
// read ports and one clocked write port. Entry 0 is never written.
module register_file
   import register_file_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter bit          BYPASS     = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  reg_write,
   input  logic [ADDR_WIDTH-1:0] write_reg,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read_reg1,
   input  logic [ADDR_WIDTH-1:0] read_reg2,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DATA_WIDTH-1:0] regs_d [DEPTH];
   logic                  writeEnable;

   // A write only lands when enabled and aimed at a non-zero register
   always_comb begin
      writeEnable = reg_write && (write_reg != '0);
   end

   // Next-state of the array: unchanged except for the addressed entry
   always_comb begin
      regs_d = regs_q;
      if (writeEnable) begin
         regs_d[write_reg] = write_data;
      end
   end

   // Storage update; reset clears every entry and discards a coincident write
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   register_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYPASS     (BYPASS)
   ) readPort1 (
      .rst_i        (rst),
      .readReg_i    (read_reg1),
      .storedData_i (regs_q[read_reg1]),
      .writeEn_i    (reg_write),
      .writeReg_i   (write_reg),
      .writeData_i  (write_data),
      .readData_o   (read_data1)
   );

   register_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYPASS     (BYPASS)
   ) readPort2 (
      .rst_i        (rst),
      .readReg_i    (read_reg2),
      .storedData_i (regs_q[read_reg2]),
      .writeEn_i    (reg_write),
      .writeReg_i   (write_reg),
      .writeData_i  (write_data),
      .readData_o   (read_data2)
   );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: one bypassing and one
// non-bypassing instance share stimulus and are compared every cycle
// against a plain array model, with directed literal checks on top.
module tb_register_file;
   import register_file_pkg::*;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk;
   logic          rst;
   logic          regWrite;
   logic [AW-1:0] writeReg;
   logic [DW-1:0] writeData;
   logic [AW-1:0] readReg1;
   logic [AW-1:0] readReg2;
   logic [DW-1:0] rd1Byp, rd2Byp, rd1NoByp, rd2NoByp;

   logic          muxSel;
   logic [DW-1:0] immediate;
   logic [DW-1:0] muxOut;

   logic [DW-1:0] model [DEPTH];
   int            testsRun;
   int            testsFailed;
   bit            randomPhase;

   register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b1)) dutByp (
      .clk        (clk),
      .rst        (rst),
      .reg_write  (regWrite),
      .write_reg  (writeReg),
      .write_data (writeData),
      .read_reg1  (readReg1),
      .read_reg2  (readReg2),
      .read_data1 (rd1Byp),
      .read_data2 (rd2Byp)
   );

   register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b0)) dutNoByp (
      .clk        (clk),
      .rst        (rst),
      .reg_write  (regWrite),
      .write_reg  (writeReg),
      .write_data (writeData),
      .read_reg1  (readReg1),
      .read_reg2  (readReg2),
      .read_data1 (rd1NoByp),
      .read_data2 (rd2NoByp)
   );

   // Downstream ALU-source mux fed by read_data2 and an immediate
   assign muxOut = muxSel ? immediate : rd2Byp;

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Architectural state: what each register must hold after every edge
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) model[i] <= '0;
      end else if (regWrite && writeReg != 0) begin
         model[writeReg] <= writeData;
      end
   end

   // Value a read port must present given current inputs and model state
   function automatic logic [DW-1:0] expRead(input logic [AW-1:0] idx, input bit bypass);
      if (rst) return '0;
      if (idx == 0) return '0;
      if (bypass && regWrite && writeReg == idx) return writeData;
      return model[idx];
   endfunction

   task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit we, input logic [AW-1:0] wr,
                                input logic [DW-1:0] wd, input logic [AW-1:0] r1,
                                input logic [AW-1:0] r2);
      @(posedge clk);
      #1;
      rst       = r;
      regWrite  = we;
      writeReg  = wr;
      writeData = wd;
      readReg1  = r1;
      readReg2  = r2;
   endtask

   // Every cycle, mid-period, all four read outputs against the model
   always @(negedge clk) begin
      checkOutput("byp.rd1",   rd1Byp,   expRead(readReg1, 1'b1));
      checkOutput("byp.rd2",   rd2Byp,   expRead(readReg2, 1'b1));
      checkOutput("nobyp.rd1", rd1NoByp, expRead(readReg1, 1'b0));
      checkOutput("nobyp.rd2", rd2NoByp, expRead(readReg2, 1'b0));
   end

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      randomPhase = 1'b0;
      rst       = 1'b1;
      regWrite  = 1'b0;
      writeReg  = '0;
      writeData = '0;
      readReg1  = 5'd5;
      readReg2  = 5'd5;
      muxSel    = 1'b0;
      immediate = '0;

      // Before any edge, reset forces zero
      #2;
      checkOutput("preEdge.rd1", rd1Byp, 32'h0);
      checkOutput("preEdge.rd2", rd2Byp, 32'h0);

      applyStimulus(1, 0, 0, 0, 5, 5);
      applyStimulus(1, 0, 0, 0, 5, 5);

      // Reset clear
      applyStimulus(0, 1, 5, 32'hDEADBEEF, 5, 5);
      applyStimulus(1, 0, 0, 0, 5, 5);
      #1;
      checkOutput("rstHigh.rd1", rd1Byp, 32'h0);
      checkOutput("rstHigh.rd2", rd2NoByp, 32'h0);
      applyStimulus(0, 0, 0, 0, 5, 5);
      #1;
      checkOutput("rstClear.rd1", rd1Byp, 32'h0);
      checkOutput("rstClear.rd2", rd2Byp, 32'h0);

      // Basic write/read
      applyStimulus(0, 1, REG_T0[AW-1:0], 32'h00000005, 9, 9);
      applyStimulus(0, 0, 0, 0, REG_T0[AW-1:0], REG_T0[AW-1:0]);
      #1;
      checkOutput("basic.rd1", rd1Byp, 32'h00000005);
      checkOutput("basic.rd2", rd2NoByp, 32'h00000005);
      applyStimulus(0, 0, 0, 0, 9, REG_T0[AW-1:0]);
      #1;
      checkOutput("unwritten.rd1", rd1Byp, 32'h0);

      // Register 0 ignores writes and never bypasses
      applyStimulus(0, 1, 0, 32'hFFFFFFFF, 0, 0);
      #1;
      checkOutput("r0Write.rd1", rd1Byp, 32'h0);
      checkOutput("r0Write.rd2", rd2Byp, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("r0After.rd1", rd1NoByp, 32'h0);
      checkOutput("r0After.rd2", rd2Byp, 32'h0);

      // Bypass versus stored value on r31
      applyStimulus(0, 1, REG_RA[AW-1:0], 32'h11111111, 0, 0);
      applyStimulus(0, 1, REG_RA[AW-1:0], 32'h22222222, REG_RA[AW-1:0], REG_RA[AW-1:0]);
      #1;
      checkOutput("bypass.rd1", rd1Byp, 32'h22222222);
      checkOutput("bypass.rd2", rd2Byp, 32'h22222222);
      checkOutput("noBypass.rd2", rd2NoByp, 32'h11111111);
      applyStimulus(0, 0, 0, 0, 0, REG_RA[AW-1:0]);
      #1;
      checkOutput("noBypassAfter.rd2", rd2NoByp, 32'h22222222);

      // Reset beats a coincident write
      applyStimulus(1, 1, REG_SP[AW-1:0], 32'h12345678, 0, 0);
      applyStimulus(0, 0, 0, 0, REG_SP[AW-1:0], REG_SP[AW-1:0]);
      #1;
      checkOutput("rstPriority.rd1", rd1Byp, 32'h0);
      checkOutput("rstPriority.rd2", rd2NoByp, 32'h0);

      // ALU-source mux integration
      applyStimulus(0, 1, 10, 32'h00000005, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 10);
      muxSel = 1'b0;
      #1;
      checkOutput("muxSel0", muxOut, 32'h00000005);
      muxSel    = 1'b1;
      immediate = 32'h00000005;
      #1;
      checkOutput("muxSel1", muxOut, 32'h00000005);
      muxSel = 1'b0;

      // Randomized traffic, addresses biased toward a few indices for hits
      randomPhase = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         logic          r, we;
         logic [AW-1:0] wr, r1, r2;
         r  = ($urandom_range(0, 39) == 0);
         we = $urandom_range(0, 1) == 1;
         wr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3));
         r1 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3));
         r2 = ($urandom_range(0, 3) == 0) ? r1 :
              (($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3)));
         applyStimulus(r, we, wr, $urandom, r1, r2);
      end

      applyStimulus(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
